// File: rtl/klein_dec_serial.sv
// KLEIN-96 byte-serial decryption core.
// Takes ciphertext and key a byte at a time, expands the key to the last
// round key, runs the inverse rounds one per cycle and returns the
// plaintext a byte at a time.
module klein_dec_serial #(
  parameter int ROUNDS = 20
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam logic [4:0] LAST = 5'(ROUNDS);

  typedef enum logic [2:0] {IDLE, LOAD, KEXP, DEC, OUT} state_t;

  state_t      state, next_state;
  logic [3:0]  byte_cnt;
  logic [4:0]  rnd;
  logic [63:0] st;
  logic [95:0] key;
  logic        rdy_en;

  logic        accept;
  logic        out_fire;
  logic [4:0]  step_idx;
  logic [4:0]  round_idx;
  logic [95:0] key_next;
  logic [95:0] key_prev;
  logic [63:0] round_out;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h7;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'h9;
      4'h4: sbox = 4'h1;  4'h5: sbox = 4'hF;  4'h6: sbox = 4'hB;  4'h7: sbox = 4'h0;
      4'h8: sbox = 4'hC;  4'h9: sbox = 4'h3;  4'hA: sbox = 4'h2;  4'hB: sbox = 4'h6;
      4'hC: sbox = 4'h8;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hD;  default: sbox = 4'h5;
    endcase
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  function automatic logic [63:0] sub_state(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = sub_byte(s[8*j +: 8]);
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int j = 0; j < 4; j++) begin
      a[j]  = c[8*(3-j) +: 8];
      x2    = xtime(a[j]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[j] = x8 ^ a[j];
      mb[j] = x8 ^ x2 ^ a[j];
      md[j] = x8 ^ x4 ^ a[j];
      me[j] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Forward key step: byte-rotate both halves, Feistel swap, round
  // constant into a' byte 2, S-box on b' bytes 1 and 2.
  function automatic logic [95:0] key_fwd(input logic [95:0] k, input logic [4:0] i);
    logic [47:0] a_rot, b_rot, na, nb;
    a_rot = {k[87:48], k[95:88]};
    b_rot = {k[39:0], k[47:40]};
    na = b_rot;
    nb = a_rot ^ b_rot;
    na[31:24] = na[31:24] ^ {3'b000, i};
    nb[39:32] = sub_byte(nb[39:32]);
    nb[31:24] = sub_byte(nb[31:24]);
    return {na, nb};
  endfunction

  // Exact inverse of key_fwd; the S-box is its own inverse.
  function automatic logic [95:0] key_inv(input logic [95:0] k, input logic [4:0] i);
    logic [47:0] na, nb, a_rot, b_rot;
    na = k[95:48];
    nb = k[47:0];
    nb[39:32] = sub_byte(nb[39:32]);
    nb[31:24] = sub_byte(nb[31:24]);
    na[31:24] = na[31:24] ^ {3'b000, i};
    b_rot = na;
    a_rot = nb ^ na;
    return {a_rot[7:0], a_rot[47:8], b_rot[7:0], b_rot[47:8]};
  endfunction

  // One inverse round: InvMix, rotate right two bytes, S-box, add key.
  function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] m, r;
    m = {inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    r = {m[15:0], m[63:16]};
    return sub_state(r) ^ rk;
  endfunction

  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign step_idx  = rnd + 5'd1;
  assign round_idx = LAST + 5'd1 - rnd;
  assign key_next  = key_fwd(key, step_idx);
  assign key_prev  = key_inv(key, round_idx);
  assign round_out = dec_round(st, key_prev[95:32]);

  // Enables in_ready one edge after reset is released.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) next_state = LOAD;
      end
      LOAD: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en && byte_cnt == 4'd11) next_state = KEXP;
      end
      KEXP: if (rnd == LAST - 5'd1) next_state = DEC;
      DEC:  if (rnd == LAST) next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_data  = st[63:56];
        if (out_ready && byte_cnt == 4'd7) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: byte shift-in, key expansion, rounds and byte shift-out.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      rnd      <= '0;
      st       <= '0;
      key      <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (byte_cnt < 4'd8) st <= {st[55:0], in_data};
            key      <= {key[87:0], in_key};
            byte_cnt <= (byte_cnt == 4'd11) ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        KEXP: begin
          key <= key_next;
          rnd <= (rnd == LAST - 5'd1) ? 5'd0 : rnd + 5'd1;
        end
        DEC: begin
          if (rnd == 5'd0) begin
            st <= st ^ key[95:32];
          end else begin
            st  <= round_out;
            key <= key_prev;
          end
          rnd <= (rnd == LAST) ? 5'd0 : rnd + 5'd1;
        end
        OUT: begin
          if (out_fire) begin
            st       <= {st[55:0], st[63:56]};
            byte_cnt <= (byte_cnt == 4'd7) ? 4'd0 : byte_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
